// File: rtl/func_call_arbiter.sv
// Round-robin arbiter sharing one multi-cycle adder between NUM_REQ requesters.
// One transaction in flight; the result returns tagged with the owner's id.
module func_call_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;

    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   scan_idx;
    logic              in_idle;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = in_idle & grant_found & (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Held low during reset so no requester sees a phantom accept.
    assign in_idle = rst_n & (state_reg == IDLE);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        cnt_next       = cnt_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        id_next        = id_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_id_next    = rsp_id_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    a_next  = a_arr[grant_idx];
                    b_next  = b_arr[grant_idx];
                    id_next = grant_idx;
                    if (LATENCY == 1) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = a_arr[grant_idx] + b_arr[grant_idx];
                        rsp_id_next    = grant_idx;
                    end else begin
                        state_next = EXEC;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            EXEC: begin
                if (cnt_reg == '0) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = a_reg + b_reg;
                    rsp_id_next    = id_reg;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    rr_ptr_next    = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            cnt_reg       <= cnt_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            id_reg        <= id_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_id_reg    <= rsp_id_next;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg != IDLE);
endmodule
